clz_pipe: RTL and testbench
===========================

Name: clz_pipe

Overview:
Pipelined, handshaked leading-bit counter and normaliser for the Newton datapath. It generalises the combinational count-leading-zeros unit in three ways: any power-of-two width, a configurable register-stage count, and a per-transaction mode (leading zeros, leading ones, redundant sign bits). Each result also carries the input left-shifted by the count. It feeds the fixed-point normalisation and range-reduction logic.

Parameters:
BITS_IN, 16, operand width; power of two, minimum 4.
BITS_OUT, 4, clog2(BITS_IN); derived, never overridden.
STAGES, 2, register stages from accept to output; legal range 1..BITS_OUT.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  input transaction present.
in_ready  output  1  block can accept a transaction this cycle.
in_data  input  BITS_IN  operand.
in_mode  input  2  00 = CLZ, 01 = CLO, 10 = CLS; 11 is reserved and behaves as CLZ.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
out_count  output  BITS_OUT+1  leading count, range 0..BITS_IN.
out_found  output  1  a terminating bit exists (the equivalent of the combinational vout).
out_norm  output  BITS_IN  in_data << out_count, zero-filled.

Behaviour:
- Reset (rst_n low, async): all stage valid bits clear; out_valid=0, out_count=0, out_found=0, out_norm=0. Any in-flight data is discarded. in_ready=1 from the first clock edge after rst_n rises.
- Global-enable pipeline: adv = !out_valid || out_ready; in_ready = adv.
  - Every stage (data and valid) loads only when adv=1 and holds otherwise.
  - An intermediate bubble stays a bubble and is not collapsed.
- Accept on in_valid && in_ready. Latency is exactly STAGES cycles with no stall: accept at edge N, out_valid=1 after edge N+STAGES-1. Throughput is 1 per cycle while out_ready=1.
- Outputs are stable while out_valid && !out_ready.
- CLZ: count of leading zeros. Input 0 gives count=BITS_IN, found=0.
- CLO: count of leading ones; implemented as CLZ of ~in_data. All-ones input gives count=BITS_IN, found=0.
- CLS: number of bits after the MSB that equal the MSB (redundant sign bits).
  - Result = CLZ(in_data ^ (in_data >> 1) with MSB forced 0) - 1.
  - All-equal input gives count=BITS_IN-1, found=0.
  - Otherwise found=1.
- out_norm = in_data << out_count, computed in the final stage.
  - A count of BITS_IN gives out_norm=0.
- Tree structure:
  - Level 0 encodes bit pairs.
  - Each subsequent level combines two halves: if the upper half is all-zero, {1, lower count}; else {0, upper count}.
  - There are BITS_OUT levels.
  - STAGES registers are spread across the levels: a register after every ceil(BITS_OUT/STAGES) levels, with the final register always at the output.
  - in_data and in_mode travel alongside the tree for the normaliser.
- Simultaneous accept and consume in the same cycle is legal and loses nothing.
- A reset asserted mid-stall drops the held result; no partial output is produced.

Decomposition:
- utils.vh (shared header) holds:
  - the clog2 function;
  - mode encodings CLZ_MODE_Z=2'b00, CLZ_MODE_O=2'b01, CLZ_MODE_S=2'b10;
  - a STAGE_SPACING macro.
- One sub-module, clz_node: combinational merge of two half-results (valid, count) of parametrised width into one result. It is instantiated per tree node via generate.
- The pipeline registers and the handshake live in clz_pipe.

Test Plan:
- BITS_IN=16, STAGES=2, out_ready=1; CLZ of 16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h0001 on consecutive cycles:
  - out_valid high two cycles after each accept, back to back;
  - counts 16, 0, 8, 0, 15;
  - found 0, 1, 1, 1, 1;
  - norm 0000, FFFF, FF00, FF00, 8000.
- CLO of 16'hFF00 gives count=8, found=1, norm=0000. CLO of 16'hFFFF gives count=16, found=0.
- CLS of 16'hFFF0 gives count=11; of 16'h0003 gives 13; of 16'h0000 and 16'hFFFF gives 15 with found=0; of 16'h4000 gives 0.
- Backpressure: send 4 operands with out_ready=0.
  - in_ready drops once out_valid=1; the first result is held stable.
  - Release out_ready: all 4 results emerge in order, none duplicated or lost.
- Pulse rst_n low asynchronously between edges while results are held:
  - outputs clear immediately;
  - no stale result after release;
  - in_ready=1 on the next edge.
- Sweep BITS_IN in {4, 32}, STAGES in {1, BITS_OUT}; random operands and modes vs a behavioural model.
  - Latency equals STAGES; every result matches the model.

Source files
------------

// File: rtl/clz_pipe_pkg.sv
// Shared definitions for the pipelined leading-bit counter.
// Mode encodings and elaboration-time helpers for stage placement.
package clz_pipe_pkg;

  localparam logic [1:0] CLZ_MODE_Z = 2'b00;
  localparam logic [1:0] CLZ_MODE_O = 2'b01;
  localparam logic [1:0] CLZ_MODE_S = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Tree levels packed into one register stage.
  function automatic int stage_spacing(
    input int levels,
    input int stages
  );
    return (levels + stages - 1) / stages;
  endfunction

  // Deepest tree level whose result is captured by register rank b.
  function automatic int cap_level(
    input int b,
    input int sp,
    input int levels
  );
    int top;
    top = (b + 1) * sp;
    if (top > levels) top = levels;
    return top - 1;
  endfunction

endpackage

// File: rtl/clz_node.sv
// One merge node of the leading-zero tree.
// Combines the upper and lower half results into a wider count.
module clz_node #(
  parameter int W = 1
) (
  input  logic         hi_v,
  input  logic [W-1:0] hi_c,
  input  logic         lo_v,
  input  logic [W-1:0] lo_c,
  output logic         v,
  output logic [W:0]   c
);

  // Upper half empty: count spans it and continues into the lower half.
  always_comb begin
    v = hi_v | lo_v;
    c = hi_v ? {1'b0, hi_c} : {1'b1, lo_c};
  end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading zero/one/sign counter with normalised output.
// Tree levels are split across STAGES registers under one global enable.
module clz_pipe
  import clz_pipe_pkg::*;
#(
  parameter int BITS_IN  = 16,
  parameter int BITS_OUT = clog2(BITS_IN),
  parameter int STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS_IN-1:0]  in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS_OUT:0]   out_count,
  output logic                out_found,
  output logic [BITS_IN-1:0]  out_norm
);

  localparam int BO = BITS_OUT;
  localparam int SP = stage_spacing(BO, STAGES);
  localparam int LS = (BO - 1) / SP;
  localparam logic [BO:0] CNT_FULL = (BO + 1)'(BITS_IN);
  localparam logic [BO:0] CNT_ONE  = (BO + 1)'(1);

  logic               adv;
  logic               acc;
  logic               rdy_q;
  logic [BITS_IN-1:0] x;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rdy_q;
  assign acc      = in_valid && in_ready;

  // Hold off acceptance until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Map every mode onto a plain leading-zero search.
  always_comb begin
    x = in_data;
    unique case (1'b1)
      in_mode == CLZ_MODE_O:
        x = ~in_data;
      in_mode == CLZ_MODE_S:
        x = {1'b0,
             in_data[BITS_IN-2:0] ^ in_data[BITS_IN-1:1]};
      default:
        x = in_data;
    endcase
  end

  for (genvar k = 0; k < BO; k++) begin : g_lvl
    localparam int N = BITS_IN >> (k + 1);
    logic [N-1:0]      v;
    logic [N-1:0][k:0] c;

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_n
        assign v[j] = x[2*j+1] | x[2*j];
        assign c[j] = !x[2*j+1];
      end
    end else begin : g_merge
      logic [2*N-1:0]        iv;
      logic [2*N-1:0][k-1:0] ic;

      if (k % SP == 0) begin : g_src_reg
        assign iv = g_reg[k/SP-1].v;
        assign ic = g_reg[k/SP-1].c;
      end else begin : g_src_comb
        assign iv = g_lvl[k-1].v;
        assign ic = g_lvl[k-1].c;
      end

      for (genvar j = 0; j < N; j++) begin : g_n
        clz_node #(
          .W (k)
        ) u_node (
          .hi_v (iv[2*j+1]),
          .hi_c (ic[2*j+1]),
          .lo_v (iv[2*j]),
          .lo_c (ic[2*j]),
          .v    (v[j]),
          .c    (c[j])
        );
      end
    end
  end

  for (genvar b = 0; b < STAGES - 1; b++) begin : g_reg
    localparam int L = cap_level(b, SP, BO);
    localparam int N = BITS_IN >> (L + 1);
    logic               vld;
    logic [BITS_IN-1:0] d;
    logic [1:0]         m;
    logic [N-1:0]       v;
    logic [N-1:0][L:0]  c;
    logic               vld_nx;
    logic [BITS_IN-1:0] d_nx;
    logic [1:0]         m_nx;
    logic [N-1:0]       v_nx;
    logic [N-1:0][L:0]  c_nx;

    if (b == 0) begin : g_in
      assign vld_nx = acc;
      assign d_nx   = in_data;
      assign m_nx   = in_mode;
    end else begin : g_prev
      assign vld_nx = g_reg[b-1].vld;
      assign d_nx   = g_reg[b-1].d;
      assign m_nx   = g_reg[b-1].m;
    end

    if (b <= LS) begin : g_tree
      assign v_nx = g_lvl[L].v;
      assign c_nx = g_lvl[L].c;
    end else begin : g_pass
      assign v_nx = g_reg[b-1].v;
      assign c_nx = g_reg[b-1].c;
    end

    // Intermediate rank: loads only when the whole pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        d   <= '0;
        m   <= '0;
        v   <= '0;
        c   <= '0;
      end else if (adv) begin
        vld <= vld_nx;
        d   <= d_nx;
        m   <= m_nx;
        v   <= v_nx;
        c   <= c_nx;
      end
    end
  end

  logic               fvld;
  logic [BITS_IN-1:0] fd;
  logic [1:0]         fm;
  logic               fv;
  logic [BO-1:0]      fc;

  if (STAGES == 1) begin : g_fin_in
    assign fvld = acc;
    assign fd   = in_data;
    assign fm   = in_mode;
  end else begin : g_fin_reg
    assign fvld = g_reg[STAGES-2].vld;
    assign fd   = g_reg[STAGES-2].d;
    assign fm   = g_reg[STAGES-2].m;
  end

  if (LS == STAGES - 1) begin : g_fin_tree
    assign fv = g_lvl[BO-1].v[0];
    assign fc = g_lvl[BO-1].c[0];
  end else begin : g_fin_pass
    assign fv = g_reg[STAGES-2].v[0];
    assign fc = g_reg[STAGES-2].c[0];
  end

  logic [BO:0]        cnt_nx;
  logic [BITS_IN-1:0] norm_nx;

  // Final count: empty tree means full width; sign mode drops the MSB.
  always_comb begin
    cnt_nx = fv ? {1'b0, fc} : CNT_FULL;
    if (fm == CLZ_MODE_S) cnt_nx = cnt_nx - CNT_ONE;
    norm_nx = fd << cnt_nx;
  end

  // Output rank: results hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_found <= 1'b0;
      out_norm  <= '0;
    end else if (adv) begin
      out_valid <= fvld;
      out_count <= cnt_nx;
      out_found <= fv;
      out_norm  <= norm_nx;
    end
  end

endmodule

// File: tb/tb_clz_pipe.sv
// Directed and randomized checks for clz_pipe.
// Reference results come from a bit-scanning model of the count rules.
module tb_clz_pipe;
  import clz_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid, in_ready, out_valid, out_ready, out_found;
  logic [15:0] in_data, out_norm;
  logic [1:0]  in_mode;
  logic [4:0]  out_count;

  clz_pipe #(.BITS_IN(16), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_found(out_found),
    .out_norm(out_norm)
  );

  logic        sw_valid, sw_ready;
  logic [31:0] sw_data;
  logic [1:0]  sw_mode;

  logic a_ir, a_ov, a_of; logic [2:0] a_oc; logic [3:0]  a_on;
  logic b_ir, b_ov, b_of; logic [2:0] b_oc; logic [3:0]  b_on;
  logic c_ir, c_ov, c_of; logic [5:0] c_oc; logic [31:0] c_on;
  logic e_ir, e_ov, e_of; logic [5:0] e_oc; logic [31:0] e_on;

  clz_pipe #(.BITS_IN(4), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(a_ir),
    .in_data(sw_data[3:0]), .in_mode(sw_mode),
    .out_valid(a_ov), .out_ready(sw_ready),
    .out_count(a_oc), .out_found(a_of), .out_norm(a_on)
  );
  clz_pipe #(.BITS_IN(4), .STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(b_ir),
    .in_data(sw_data[3:0]), .in_mode(sw_mode),
    .out_valid(b_ov), .out_ready(sw_ready),
    .out_count(b_oc), .out_found(b_of), .out_norm(b_on)
  );
  clz_pipe #(.BITS_IN(32), .STAGES(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(c_ir),
    .in_data(sw_data), .in_mode(sw_mode),
    .out_valid(c_ov), .out_ready(sw_ready),
    .out_count(c_oc), .out_found(c_of), .out_norm(c_on)
  );
  clz_pipe #(.BITS_IN(32), .STAGES(5)) u_e (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(e_ir),
    .in_data(sw_data), .in_mode(sw_mode),
    .out_valid(e_ov), .out_ready(sw_ready),
    .out_count(e_oc), .out_found(e_of), .out_norm(e_on)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan from the top while bits match the counted value.
  function automatic void model(
    input  logic [31:0] d,
    input  int          w,
    input  logic [1:0]  m,
    output int          cnt,
    output logic        fnd,
    output logic [63:0] nrm
  );
    logic top;
    int   lim;
    cnt = 0;
    if (m == 2'b10) begin
      top = d[w-1];
      lim = w - 1;
      for (int i = w - 2; i >= 0 && d[i] == top; i--) cnt++;
    end else begin
      top = (m == 2'b01);
      lim = w;
      for (int i = w - 1; i >= 0 && d[i] == top; i--) cnt++;
    end
    fnd = (cnt < lim);
    nrm = ({32'b0, d} << cnt) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    r = $urandom >> $urandom_range(0, 31);
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = '1;
      2, 3:    r = ~r;
      default: r = r;
    endcase
    return r;
  endfunction

  localparam int NSW = 80;
  logic        hv [NSW+6];
  logic [31:0] hd [NSW+6];
  logic [1:0]  hm [NSW+6];

  task automatic sw_chk(
    input string       tag,
    input int          w,
    input int          s,
    input int          i,
    input logic        ir,
    input logic        ov,
    input logic [63:0] oc,
    input logic        of,
    input logic [63:0] on
  );
    logic        ev;
    int          cnt;
    logic        fnd;
    logic [63:0] nrm;
    ev = (i >= s) ? hv[i-s] : 1'b0;
    chk({tag, " ready"}, ir, 1'b1);
    chk({tag, " valid"}, ov, ev);
    if (ev) begin
      model(hd[i-s], w, hm[i-s], cnt, fnd, nrm);
      chk({tag, " count"}, oc, cnt);
      chk({tag, " found"}, of, fnd);
      chk({tag, " norm"},  on, nrm);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    int          c;
    logic        f;
    logic [15:0] n;
  } vec_t;

  vec_t        vt [13];
  logic [15:0] bp [4];
  logic [15:0] bq [$];
  int          sent, got, cnt;
  logic        fnd;
  logic [63:0] nrm;

  initial begin
    vt = '{
      '{16'h0000, 2'b00, 16, 1'b0, 16'h0000},
      '{16'hFFFF, 2'b00,  0, 1'b1, 16'hFFFF},
      '{16'h00FF, 2'b00,  8, 1'b1, 16'hFF00},
      '{16'hFF00, 2'b00,  0, 1'b1, 16'hFF00},
      '{16'h0001, 2'b00, 15, 1'b1, 16'h8000},
      '{16'hFF00, 2'b01,  8, 1'b1, 16'h0000},
      '{16'hFFFF, 2'b01, 16, 1'b0, 16'h0000},
      '{16'hFFF0, 2'b10, 11, 1'b1, 16'h8000},
      '{16'h0003, 2'b10, 13, 1'b1, 16'h6000},
      '{16'h0000, 2'b10, 15, 1'b0, 16'h0000},
      '{16'hFFFF, 2'b10, 15, 1'b0, 16'h8000},
      '{16'h4000, 2'b10,  0, 1'b1, 16'h4000},
      '{16'h00FF, 2'b11,  8, 1'b1, 16'hFF00}
    };
    bp = '{16'h0010, 16'h0800, 16'h2000, 16'h0003};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = '0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = '0; sw_mode = '0;
    sw_ready = 1'b1;

    #12;
    chk("reset valid", out_valid, 1'b0);
    chk("reset count", out_count, 0);
    chk("reset found", out_found, 1'b0);
    chk("reset norm",  out_norm,  0);
    chk("reset sweep valid", e_ov, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", in_ready, 1'b1);

    // back-to-back directed stream, latency 2
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i < 2) begin
        chk("latency idle", out_valid, 1'b0);
      end else begin
        chk("dir valid", out_valid, 1'b1);
        chk("dir count", out_count, vt[i-2].c);
        chk("dir found", out_found, vt[i-2].f);
        chk("dir norm",  out_norm,  vt[i-2].n);
      end
      if (i == 5) chk("dir ready", in_ready, 1'b1);
      if (i < 13) begin
        in_valid = 1'b1;
        in_data  = vt[i].d;
        in_mode  = vt[i].m;
      end else begin
        in_valid = 1'b0;
      end
    end

    // backpressure: fill with the consumer stalled
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    sent = 0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready && sent < 4) begin
        in_valid = 1'b1;
        in_data  = bp[sent];
        in_mode  = 2'b00;
        bq.push_back(bp[sent]);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    model({16'b0, bp[0]}, 16, 2'b00, cnt, fnd, nrm);
    chk("bp ready low", in_ready, 1'b0);
    chk("bp held valid", out_valid, 1'b1);
    chk("bp held count", out_count, cnt);
    repeat (3) @(negedge clk);
    chk("bp stable count", out_count, cnt);
    chk("bp stable norm",  out_norm,  nrm);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid && bq.size() > 0) begin
        model({16'b0, bq.pop_front()}, 16, 2'b00, cnt, fnd, nrm);
        chk("bp order count", out_count, cnt);
        chk("bp order norm",  out_norm,  nrm);
        got++;
      end else if (out_valid) begin
        chk("bp extra result", out_valid, 1'b0);
      end
      if (in_ready && sent < 4) begin
        in_valid = 1'b1;
        in_data  = bp[sent];
        bq.push_back(bp[sent]);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (sent == 4 && bq.size() == 0) break;
      @(negedge clk);
    end
    chk("bp received", got, 4);
    repeat (3) begin
      @(negedge clk);
      chk("bp no duplicate", out_valid, 1'b0);
    end

    // async reset while a result is held
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0100; in_mode = 2'b00;
    @(negedge clk);
    in_data = 16'h0F00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst held valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst clr valid", out_valid, 1'b0);
    chk("rst clr count", out_count, 0);
    chk("rst clr found", out_found, 1'b0);
    chk("rst clr norm",  out_norm,  0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst ready next edge", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst no stale", out_valid, 1'b0);
    end

    // random sweep over widths and depths
    for (int i = 0; i < NSW + 6; i++) begin
      @(negedge clk);
      sw_chk("w4s1",  4,  1, i, a_ir, a_ov, a_oc, a_of, a_on);
      sw_chk("w4s2",  4,  2, i, b_ir, b_ov, b_oc, b_of, b_on);
      sw_chk("w32s1", 32, 1, i, c_ir, c_ov, c_oc, c_of, c_on);
      sw_chk("w32s5", 32, 5, i, e_ir, e_ov, e_oc, e_of, e_on);
      if (i < NSW) begin
        hv[i] = ($urandom_range(0, 3) != 0);
        hd[i] = gen();
        hm[i] = 2'($urandom_range(0, 3));
      end else begin
        hv[i] = 1'b0;
        hd[i] = '0;
        hm[i] = '0;
      end
      sw_valid = hv[i];
      sw_data  = hd[i];
      sw_mode  = hm[i];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
